// File: rtl/next_field_sweeper_pkg.sv
// Shared types, rule constants and helpers for the next-generation field sweeper.
package next_field_sweeper_pkg;

    localparam int NEIGHBOURS_CNT = 8;

    typedef enum logic {
        FIELD_A = 1'b0,
        FIELD_B = 1'b1
    } cur_field_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        SWAP  = 2'd3
    } sweep_state_t;

    // Conway's B3/S23 rule: bit n refers to n live neighbours.
    localparam logic [8:0] RULE_BIRTH_CONWAY   = 9'b000001000;
    localparam logic [8:0] RULE_SURVIVE_CONWAY = 9'b000001100;

    // Number of live neighbours, 0..8.
    function automatic logic [3:0] nbr_count(input logic [NEIGHBOURS_CNT-1:0] nbrs);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < NEIGHBOURS_CNT; i++) begin
            cnt = cnt + {3'd0, nbrs[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/next_field_sweeper_cell_rule_lane.sv
// One lane of the generation rule: neighbour popcount followed by a lookup
// in the birth or survive mask depending on the current cell state.
module cell_rule_lane
    import next_field_sweeper_pkg::*;
(
    input  logic                      i_cell,
    input  logic [NEIGHBOURS_CNT-1:0] i_nbrs,
    input  logic [8:0]                i_birth_mask,
    input  logic [8:0]                i_survive_mask,
    output logic                      o_new_cell
);

    logic [3:0] cnt_s;

    // Pick the rule bit indexed by the live-neighbour count.
    always_comb begin
        cnt_s = nbr_count(i_nbrs);
        if (i_cell) begin
            o_new_cell = i_survive_mask[cnt_s];
        end else begin
            o_new_cell = i_birth_mask[cnt_s];
        end
    end

endmodule

// File: rtl/next_field_sweeper.sv
// Game of Life generation engine: sweeps the field LANES cells per cycle in
// raster order, applies a runtime B/S rule and writes the next generation
// one cycle after each read into the other ping-pong buffer.
// Optional feature: define POPCOUNT_EN to report the live-cell count of the
// last completed generation on o_pop_cnt (otherwise o_pop_cnt is 0).
module next_field_sweeper
    import next_field_sweeper_pkg::*;
#(
    parameter  int FIELD_W    = 64,
    parameter  int FIELD_H    = 48,
    parameter  int LANES      = 4,
    parameter  int GEN_CNT_W  = 16,
    localparam int X_ADR_SIZE = $clog2(FIELD_W),
    localparam int Y_ADR_SIZE = $clog2(FIELD_H),
    localparam int POP_W      = X_ADR_SIZE + Y_ADR_SIZE + 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_go,
    input  logic                              i_run,
    input  logic [8:0]                        i_birth_mask,
    input  logic [8:0]                        i_survive_mask,
    input  logic [LANES-1:0]                  i_cell_state_A,
    input  logic [LANES-1:0]                  i_cell_state_B,
    input  logic [LANES*NEIGHBOURS_CNT-1:0]   i_nbrs_A,
    input  logic [LANES*NEIGHBOURS_CNT-1:0]   i_nbrs_B,
    output logic                              o_is_simulating,
    output logic [X_ADR_SIZE-1:0]             o_x,
    output logic [Y_ADR_SIZE-1:0]             o_y,
    output logic                              o_we,
    output logic [X_ADR_SIZE-1:0]             o_wr_x,
    output logic [Y_ADR_SIZE-1:0]             o_wr_y,
    output logic [LANES-1:0]                  o_new_cells,
    output cur_field_t                        o_cur_read_field,
    output logic                              o_done,
    output logic [GEN_CNT_W-1:0]              o_gen_cnt,
    output logic [POP_W-1:0]                  o_pop_cnt
);

    localparam logic [X_ADR_SIZE-1:0] X_STEP = X_ADR_SIZE'(LANES);
    localparam logic [X_ADR_SIZE-1:0] X_LAST = X_ADR_SIZE'(FIELD_W - LANES);
    localparam logic [Y_ADR_SIZE-1:0] Y_LAST = Y_ADR_SIZE'(FIELD_H - 1);

    sweep_state_t                   state_q, state_d;
    logic [X_ADR_SIZE-1:0]          x_q, x_d;
    logic [Y_ADR_SIZE-1:0]          y_q, y_d;
    logic [8:0]                     birth_q, birth_d;
    logic [8:0]                     survive_q, survive_d;
    logic                           we_q, we_d;
    logic [X_ADR_SIZE-1:0]          wr_x_q, wr_x_d;
    logic [Y_ADR_SIZE-1:0]          wr_y_q, wr_y_d;
    logic [LANES-1:0]               new_cells_q, new_cells_d;
    cur_field_t                     field_q, field_d;
    logic                           sim_q, sim_d;
    logic                           done_q, done_d;
    logic [GEN_CNT_W-1:0]           gen_q, gen_d;

    logic [LANES-1:0]               cells_s;
    logic [LANES*NEIGHBOURS_CNT-1:0] nbrs_s;
    logic [LANES-1:0]               lane_new_s;

    // Route the buffer currently being read into the rule lanes.
    always_comb begin
        if (field_q == FIELD_A) begin
            cells_s = i_cell_state_A;
            nbrs_s  = i_nbrs_A;
        end else begin
            cells_s = i_cell_state_B;
            nbrs_s  = i_nbrs_B;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        cell_rule_lane u_lane (
            .i_cell         (cells_s[k]),
            .i_nbrs         (nbrs_s[k*NEIGHBOURS_CNT +: NEIGHBOURS_CNT]),
            .i_birth_mask   (birth_q),
            .i_survive_mask (survive_q),
            .o_new_cell     (lane_new_s[k])
        );
    end

    // Next-state, read address walk and mask latching.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        birth_d   = birth_q;
        survive_d = survive_q;
        case (state_q)
            IDLE: begin
                if (i_go || i_run) begin
                    state_d   = SWEEP;
                    x_d       = '0;
                    y_d       = '0;
                    birth_d   = i_birth_mask;
                    survive_d = i_survive_mask;
                end else begin
                    state_d = IDLE;
                end
            end
            SWEEP: begin
                if ((x_q == X_LAST) && (y_q == Y_LAST)) begin
                    state_d = DRAIN;
                end else if (x_q == X_LAST) begin
                    x_d = '0;
                    y_d = y_q + Y_ADR_SIZE'(1);
                end else begin
                    x_d = x_q + X_STEP;
                end
            end
            DRAIN: begin
                state_d = SWAP;
            end
            SWAP: begin
                // Free-run chains straight into the next sweep with fresh masks.
                if (i_run) begin
                    state_d   = SWEEP;
                    x_d       = '0;
                    y_d       = '0;
                    birth_d   = i_birth_mask;
                    survive_d = i_survive_mask;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Write pipe and status outputs, all computed one cycle ahead.
    always_comb begin
        we_d        = (state_q == SWEEP);
        wr_x_d      = wr_x_q;
        wr_y_d      = wr_y_q;
        new_cells_d = '0;
        if (state_q == SWEEP) begin
            wr_x_d      = x_q;
            wr_y_d      = y_q;
            new_cells_d = lane_new_s;
        end else begin
            new_cells_d = '0;
        end
        sim_d  = (state_d == SWEEP) || (state_d == DRAIN);
        done_d = (state_d == SWAP);
        if (state_d == SWAP) begin
            field_d = (field_q == FIELD_A) ? FIELD_B : FIELD_A;
            gen_d   = gen_q + GEN_CNT_W'(1);
        end else begin
            field_d = field_q;
            gen_d   = gen_q;
        end
    end

    // Sequential state for the FSM, addresses and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            birth_q     <= '0;
            survive_q   <= '0;
            we_q        <= 1'b0;
            wr_x_q      <= '0;
            wr_y_q      <= '0;
            new_cells_q <= '0;
            field_q     <= FIELD_A;
            sim_q       <= 1'b0;
            done_q      <= 1'b0;
            gen_q       <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            birth_q     <= birth_d;
            survive_q   <= survive_d;
            we_q        <= we_d;
            wr_x_q      <= wr_x_d;
            wr_y_q      <= wr_y_d;
            new_cells_q <= new_cells_d;
            field_q     <= field_d;
            sim_q       <= sim_d;
            done_q      <= done_d;
            gen_q       <= gen_d;
        end
    end

`ifdef POPCOUNT_EN
    logic [POP_W-1:0] acc_q, acc_d;
    logic [POP_W-1:0] pop_q, pop_d;
    logic [POP_W-1:0] lane_sum_s;

    // Accumulate live next-gen cells; publish the total together with o_done.
    always_comb begin
        lane_sum_s = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_sum_s = lane_sum_s + POP_W'(lane_new_s[k]);
        end
        if (state_q == SWEEP) begin
            acc_d = acc_q + lane_sum_s;
        end else if (state_d == SWEEP) begin
            acc_d = '0;
        end else begin
            acc_d = acc_q;
        end
        if (state_d == SWAP) begin
            pop_d = acc_q;
        end else begin
            pop_d = pop_q;
        end
    end

    // Population accumulator and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            pop_q <= '0;
        end else begin
            acc_q <= acc_d;
            pop_q <= pop_d;
        end
    end

    assign o_pop_cnt = pop_q;
`else
    assign o_pop_cnt = '0;
`endif

    assign o_is_simulating  = sim_q;
    assign o_x              = x_q;
    assign o_y              = y_q;
    assign o_we             = we_q;
    assign o_wr_x           = wr_x_q;
    assign o_wr_y           = wr_y_q;
    assign o_new_cells      = new_cells_q;
    assign o_cur_read_field = field_q;
    assign o_done           = done_q;
    assign o_gen_cnt        = gen_q;

endmodule
